rtc_lap_controller: RTL and testbench
=====================================

# rtc_lap_controller

Command sequencer for the stopwatch datapath. It converts single-cycle start/stop, lap and clear pulses into the counter control strobes (count init, count enable, latch). It captures up to LAP_DEPTH lap times from the 24-bit count and selects whether the live count or a recalled lap time feeds the segment-display path. It sits between the trigger/button front end and the timer/24-bit counter, and its output drives the display decoder.

## Interface
- COUNT_W, 24, width of the count bus (6 BCD digits).
- LAP_DEPTH, 4, number of lap registers; must be ≥2.
- IDX_W, $clog2(LAP_DEPTH), width of the lap index.

- i_sys_clk  in  1  system clock; the only clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start_stop  in  1  one-cycle pulse, already debounced.
- i_lap  in  1  one-cycle pulse: capture a lap (RUN) or step through recall (STOP/RECALL).
- i_clear  in  1  one-cycle pulse: zero the counter and flush laps.
- i_count  in  COUNT_W  live count from the 24-bit counter.
- o_countinit  out  1  one-cycle counter-zero strobe.
- o_countenb  out  1  counter/timer enable level.
- o_latchcount  out  1  one-cycle latch strobe to the counter.
- o_disp_count  out  COUNT_W  value sent to the display decoder.
- o_lap_idx  out  IDX_W  lap entry currently shown; 0 outside RECALL.
- o_lap_cnt  out  IDX_W+1  number of stored laps, 0..LAP_DEPTH.
- o_lap_full  out  1  high when o_lap_cnt == LAP_DEPTH.
- o_recall  out  1  high in RECALL.

## Operation
- States: IDLE, RUN, STOP, RECALL. Reset enters IDLE.
- Command priority within a cycle: i_clear > i_start_stop > i_lap. Lower-priority pulses in the same cycle are discarded.
- IDLE:
  - start_stop → RUN.
  - lap → ignored.
  - clear → o_countinit pulse; stay in IDLE.
- RUN:
  - o_countenb=1.
  - start_stop → STOP, with an o_latchcount pulse.
  - lap → o_latchcount pulse; i_count written to lap[o_lap_cnt]; o_lap_cnt increments.
  - If the lap buffer is full, lap is dropped. No overwrite and no latch pulse.
  - clear → ignored. The count must be stopped before it can be cleared.
- STOP:
  - o_countenb=0.
  - start_stop → RUN, resuming without init.
  - lap with o_lap_cnt>0 → RECALL with idx=0. lap with o_lap_cnt=0 → ignored.
  - clear → IDLE; o_countinit pulse; o_lap_cnt=0.
- RECALL:
  - lap → idx increments, wrapping from o_lap_cnt-1 to 0.
  - start_stop → STOP; idx returns to 0.
  - clear → IDLE; o_countinit pulse; laps flushed.
  - The counter stays disabled throughout RECALL.
- Display select:
  - RECALL: o_disp_count = lap[idx].
  - Every other state: o_disp_count = i_count.
- Lap registers are not reset individually. Their contents are undefined until written and are qualified only by o_lap_cnt.

## Timing
- All outputs are registered. Response appears on the first rising edge after the edge that samples the command pulse (1-cycle latency).
- o_countinit and o_latchcount are exactly 1 cycle wide and never asserted in the same cycle.
- o_countenb rises 1 cycle after start_stop is sampled in IDLE/STOP, and falls 1 cycle after start_stop is sampled in RUN.
- Lap capture stores the i_count value sampled on the same edge that samples i_lap.
- o_disp_count lags i_count by 1 cycle outside RECALL. In RECALL it shows the new entry 1 cycle after the step pulse.
- Reset values (asynchronous, immediate):
  - state=IDLE, o_countinit=0, o_countenb=0, o_latchcount=0.
  - o_disp_count=0, o_lap_idx=0, o_lap_cnt=0, o_lap_full=0, o_recall=0.
- Reset asserted mid-RUN or mid-RECALL aborts immediately. Laps are lost and no init strobe is issued. Deassertion is synchronised externally.
- Back-to-back pulses on consecutive cycles are each processed in order; no command is lost except by priority or by the rules above.

## Test plan
- Reset mid-RUN with o_lap_cnt=2 → all outputs at reset values within the same cycle; after release, state IDLE and o_countenb=0.
- IDLE, start_stop at cycle 10 → o_countenb=1 from cycle 11. start_stop at cycle 50 → o_latchcount=1 for cycle 51 only, o_countenb=0 from 51.
- RUN with i_count=0x000123, lap → o_lap_cnt=1. Later STOP, then lap → o_recall=1, o_disp_count=0x000123, o_lap_idx=0.
- RUN, 5 laps with LAP_DEPTH=4 → o_lap_cnt=4, o_lap_full=1, only 4 latch pulses; 5th count not stored.
- RECALL with 3 laps, 4 lap pulses → o_lap_idx sequence 1,2,0,1. Then start_stop → STOP, o_lap_idx=0, o_disp_count tracks i_count.
- STOP, clear+start_stop+lap in the same cycle → only clear is acted on: o_countinit 1-cycle pulse, state IDLE, o_lap_cnt=0, o_countenb stays 0.

Source files
------------

// File: rtl/rtc_lap_controller.sv
// Stopwatch command sequencer: turns start/stop, lap and clear pulses into
// counter control strobes, stores up to LAP_DEPTH lap times and selects the
// live count or a recalled lap for the display path. All outputs registered.
module rtc_lap_controller #(
    parameter int unsigned COUNT_W   = 24,
    parameter int unsigned LAP_DEPTH = 4,
    parameter int unsigned IDX_W     = $clog2(LAP_DEPTH)
) (
    input  logic               i_sys_clk,
    input  logic               i_reset_n,
    input  logic               i_start_stop,
    input  logic               i_lap,
    input  logic               i_clear,
    input  logic [COUNT_W-1:0] i_count,
    output logic               o_countinit,
    output logic               o_countenb,
    output logic               o_latchcount,
    output logic [COUNT_W-1:0] o_disp_count,
    output logic [IDX_W-1:0]   o_lap_idx,
    output logic [IDX_W:0]     o_lap_cnt,
    output logic               o_lap_full,
    output logic               o_recall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOP,
        S_RECALL
    } state_t;

    localparam logic [IDX_W:0] FULL_CNT = LAP_DEPTH[IDX_W:0];

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W:0]       cnt_q, cnt_d;
    logic                 init_q, init_d;
    logic                 latch_q, latch_d;
    logic                 enb_q, enb_d;
    logic                 recall_q, recall_d;
    logic                 full_q, full_d;
    logic [COUNT_W-1:0]   disp_q, disp_d;
    logic                 lap_we;
    logic [COUNT_W-1:0]   lap_q [LAP_DEPTH];

    logic cmd_clear, cmd_ss, cmd_lap;

    // Priority decode: clear beats start/stop beats lap; losers are dropped
    always_comb begin
        cmd_clear = i_clear;
        cmd_ss    = i_start_stop & ~i_clear;
        cmd_lap   = i_lap & ~i_start_stop & ~i_clear;
    end

    // Next-state, lap bookkeeping and registered-output next values
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        init_d  = 1'b0;
        latch_d = 1'b0;
        lap_we  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_clear) begin
                    init_d = 1'b1;
                end else if (cmd_ss) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // clear is ignored while counting
                if (cmd_ss) begin
                    state_d = S_STOP;
                    latch_d = 1'b1;
                end else if (cmd_lap && (cnt_q != FULL_CNT)) begin
                    latch_d = 1'b1;
                    lap_we  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cmd_clear) begin
                    state_d = S_IDLE;
                    init_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cmd_ss) begin
                    state_d = S_RUN;
                end else if (cmd_lap && (cnt_q != '0)) begin
                    state_d = S_RECALL;
                    idx_d   = '0;
                end
            end
            S_RECALL: begin
                if (cmd_clear) begin
                    state_d = S_IDLE;
                    init_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cmd_ss) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                end else if (cmd_lap) begin
                    if ({1'b0, idx_q} == (cnt_q - 1'b1)) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        enb_d    = (state_d == S_RUN);
        recall_d = (state_d == S_RECALL);
        full_d   = (cnt_d == FULL_CNT);
        // Display path looks ahead at the next index so a step shows one cycle later
        disp_d   = (state_d == S_RECALL) ? lap_q[idx_d] : i_count;
    end

    // Control state and output registers, cleared asynchronously
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            init_q   <= 1'b0;
            latch_q  <= 1'b0;
            enb_q    <= 1'b0;
            recall_q <= 1'b0;
            full_q   <= 1'b0;
            disp_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            init_q   <= init_d;
            latch_q  <= latch_d;
            enb_q    <= enb_d;
            recall_q <= recall_d;
            full_q   <= full_d;
            disp_q   <= disp_d;
        end
    end

    // Lap storage: no reset, validity is carried by the lap count alone
    always_ff @(posedge i_sys_clk) begin
        if (lap_we) begin
            lap_q[cnt_q[IDX_W-1:0]] <= i_count;
        end
    end

    assign o_countinit  = init_q;
    assign o_countenb   = enb_q;
    assign o_latchcount = latch_q;
    assign o_disp_count = disp_q;
    assign o_lap_idx    = idx_q;
    assign o_lap_cnt    = cnt_q;
    assign o_lap_full   = full_q;
    assign o_recall     = recall_q;

endmodule

// File: tb/tb_rtc_lap_controller.sv
// Directed bench for rtc_lap_controller with a queue-based scoreboard fed by
// a behavioural reference model.
module tb_rtc_lap_controller;

    localparam int unsigned CW = 24;

    logic          clk;
    logic          rst_n;
    logic          i_start_stop, i_lap, i_clear;
    logic [CW-1:0] i_count;
    logic          o_countinit, o_countenb, o_latchcount;
    logic [CW-1:0] o_disp_count;
    logic [1:0]    o_lap_idx;
    logic [2:0]    o_lap_cnt;
    logic          o_lap_full, o_recall;

    rtc_lap_controller #(
        .COUNT_W   (24),
        .LAP_DEPTH (4)
    ) dut (
        .i_sys_clk    (clk),
        .i_reset_n    (rst_n),
        .i_start_stop (i_start_stop),
        .i_lap        (i_lap),
        .i_clear      (i_clear),
        .i_count      (i_count),
        .o_countinit  (o_countinit),
        .o_countenb   (o_countenb),
        .o_latchcount (o_latchcount),
        .o_disp_count (o_disp_count),
        .o_lap_idx    (o_lap_idx),
        .o_lap_cnt    (o_lap_cnt),
        .o_lap_full   (o_lap_full),
        .o_recall     (o_recall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_RUN, M_STOP, M_RECALL} mstate_t;

    typedef struct {
        logic          init;
        logic          enb;
        logic          latch;
        logic [CW-1:0] disp;
        logic [1:0]    idx;
        logic [2:0]    cnt;
        logic          full;
        logic          recall;
    } exp_t;

    exp_t          sb[$];
    mstate_t       m_st;
    int            m_idx;
    int            m_cnt;
    logic [CW-1:0] m_laps [4];
    int            n_assert;
    int            n_fail;
    int            latch_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = M_IDLE;
        m_idx = 0;
        m_cnt = 0;
    endtask

    // Reference behaviour for one sampled edge; produces the expected outputs
    task automatic model(input logic ss, input logic lp, input logic clr,
                         input logic [CW-1:0] val, output exp_t e);
        e.init  = 1'b0;
        e.latch = 1'b0;
        if (clr) begin
            if (m_st == M_STOP || m_st == M_RECALL) begin
                m_st  = M_IDLE;
                m_cnt = 0;
                m_idx = 0;
                e.init = 1'b1;
            end else if (m_st == M_IDLE) begin
                e.init = 1'b1;
            end
        end else if (ss) begin
            case (m_st)
                M_IDLE:   m_st = M_RUN;
                M_RUN:    begin m_st = M_STOP; e.latch = 1'b1; end
                M_STOP:   m_st = M_RUN;
                M_RECALL: begin m_st = M_STOP; m_idx = 0; end
                default:  m_st = M_IDLE;
            endcase
        end else if (lp) begin
            if (m_st == M_RUN && m_cnt < 4) begin
                m_laps[m_cnt] = val;
                m_cnt++;
                e.latch = 1'b1;
            end else if (m_st == M_STOP && m_cnt > 0) begin
                m_st  = M_RECALL;
                m_idx = 0;
            end else if (m_st == M_RECALL) begin
                m_idx = (m_idx + 1) % m_cnt;
            end
        end
        e.enb    = (m_st == M_RUN);
        e.recall = (m_st == M_RECALL);
        e.idx    = 2'(m_idx);
        e.cnt    = 3'(m_cnt);
        e.full   = (m_cnt == 4);
        e.disp   = (m_st == M_RECALL) ? m_laps[m_idx] : val;
    endtask

    // One command cycle: drive on the falling edge, check just after the rising edge
    task automatic step(input logic ss, input logic lp, input logic clr, input logic [CW-1:0] val);
        exp_t e;
        exp_t g;
        @(negedge clk);
        i_start_stop = ss;
        i_lap        = lp;
        i_clear      = clr;
        i_count      = val;
        model(ss, lp, clr, val, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("countinit",  32'(o_countinit),  32'(g.init));
        check("countenb",   32'(o_countenb),   32'(g.enb));
        check("latchcount", 32'(o_latchcount), 32'(g.latch));
        check("disp_count", 32'(o_disp_count), 32'(g.disp));
        check("lap_idx",    32'(o_lap_idx),    32'(g.idx));
        check("lap_cnt",    32'(o_lap_cnt),    32'(g.cnt));
        check("lap_full",   32'(o_lap_full),   32'(g.full));
        check("recall",     32'(o_recall),     32'(g.recall));
        if (o_latchcount) latch_seen++;
        i_start_stop = 1'b0;
        i_lap        = 1'b0;
        i_clear      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, CW'($urandom));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".countinit"},  32'(o_countinit),  32'd0);
        check({tag, ".countenb"},   32'(o_countenb),   32'd0);
        check({tag, ".latchcount"}, 32'(o_latchcount), 32'd0);
        check({tag, ".disp_count"}, 32'(o_disp_count), 32'd0);
        check({tag, ".lap_idx"},    32'(o_lap_idx),    32'd0);
        check({tag, ".lap_cnt"},    32'(o_lap_cnt),    32'd0);
        check({tag, ".lap_full"},   32'(o_lap_full),   32'd0);
        check({tag, ".recall"},     32'(o_recall),     32'd0);
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        latch_seen   = 0;
        rst_n        = 1'b0;
        i_start_stop = 1'b0;
        i_lap        = 1'b0;
        i_clear      = 1'b0;
        i_count      = '0;
        model_reset();

        // Power-on reset
        #12;
        check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE: lap ignored, clear gives an init pulse, then start
        idle(2);
        step(1'b0, 1'b1, 1'b0, 24'h000011);
        step(1'b0, 1'b0, 1'b1, 24'h000012);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 24'h000013);
        idle(3);

        // RUN: one lap, clear ignored, stop, recall the stored value
        step(1'b0, 1'b1, 1'b0, 24'h000123);
        step(1'b0, 1'b0, 1'b1, 24'h000130);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 24'h000140);
        check("stop.countenb", 32'(o_countenb), 32'd0);
        step(1'b0, 1'b1, 1'b0, 24'h000150);
        check("recall.disp", 32'(o_disp_count), 32'h000123);
        check("recall.flag", 32'(o_recall), 32'd1);

        // Back to STOP then RUN without init, two more laps -> 3 stored
        step(1'b1, 1'b0, 1'b0, 24'h000160);
        step(1'b1, 1'b0, 1'b0, 24'h000170);
        step(1'b0, 1'b1, 1'b0, 24'h000200);
        step(1'b0, 1'b1, 1'b0, 24'h000300);
        step(1'b1, 1'b0, 1'b0, 24'h000310);

        // RECALL with 3 laps, index walks 0 ->1,2,0,1
        step(1'b0, 1'b1, 1'b0, 24'h000320);
        step(1'b0, 1'b1, 1'b0, 24'h000330);
        check("walk.idx1", 32'(o_lap_idx), 32'd1);
        step(1'b0, 1'b1, 1'b0, 24'h000340);
        check("walk.idx2", 32'(o_lap_idx), 32'd2);
        step(1'b0, 1'b1, 1'b0, 24'h000350);
        check("walk.idx0", 32'(o_lap_idx), 32'd0);
        step(1'b0, 1'b1, 1'b0, 24'h000360);
        check("walk.idx1b", 32'(o_lap_idx), 32'd1);
        step(1'b1, 1'b0, 1'b0, 24'h000370);
        check("exit.idx", 32'(o_lap_idx), 32'd0);
        idle(2);

        // Flush, then five back-to-back laps into a 4-deep buffer
        step(1'b0, 1'b0, 1'b1, 24'h000400);
        step(1'b1, 1'b0, 1'b0, 24'h000410);
        latch_seen = 0;
        step(1'b0, 1'b1, 1'b0, 24'h001001);
        step(1'b0, 1'b1, 1'b0, 24'h001002);
        step(1'b0, 1'b1, 1'b0, 24'h001003);
        step(1'b0, 1'b1, 1'b0, 24'h001004);
        step(1'b0, 1'b1, 1'b0, 24'h001005);
        check("full.latches", 32'(latch_seen), 32'd4);
        check("full.flag", 32'(o_lap_full), 32'd1);
        step(1'b1, 1'b0, 1'b0, 24'h001010);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, CW'($urandom));

        // STOP with clear+start_stop+lap together: only clear acts
        step(1'b1, 1'b0, 1'b0, 24'h002000);
        step(1'b1, 1'b1, 1'b1, 24'h002010);
        check("combo.init", 32'(o_countinit), 32'd1);
        idle(2);

        // Reset mid-RUN with two laps stored
        step(1'b1, 1'b0, 1'b0, 24'h003000);
        step(1'b0, 1'b1, 1'b0, 24'h003001);
        step(1'b0, 1'b1, 1'b0, 24'h003002);
        check("prerst.cnt", 32'(o_lap_cnt), 32'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrun");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        step(1'b0, 1'b1, 1'b0, 24'h004000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
